// File: rtl/program_loader.sv
// Writer side of the instruction store: takes a length/bytes/checksum frame,
// writes the bytes from address 0, pads the rest with NOP and releases the CPU on success.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_FILL,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [DATA_W-1:0] DEPTH_D  = DATA_W'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_d = in_data;
          if (in_data != '0 && in_data <= DEPTH_D) state_d = S_DATA;
          else                                    state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = in_data;
          sum_d     = sum_q + in_data;
          idx_d     = idx_q + 1'b1;
          if (DATA_W'(idx_d) == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (in_data != sum_q)      state_d = S_ERR;
          else if (len_q == DEPTH_D) state_d = S_DONE;
          else                       state_d = S_FILL;
        end
      end
      S_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q[ADDR_W-1:0];
        wr_data_d = '0;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered decodes of the next state so done and cpu_hold flip together.
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
